// File: rtl/ibis_mapper_pkg.sv
// Shared types and constants for the texture forward-mapper scheduler.
package ibis_mapper_pkg;

    // Scheduler top-level states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Config select codes; the code doubles as the write_matrix bit index
    localparam logic [2:0] CFG_SEL_A  = 3'd0;
    localparam logic [2:0] CFG_SEL_B  = 3'd1;
    localparam logic [2:0] CFG_SEL_C  = 3'd2;
    localparam logic [2:0] CFG_SEL_D  = 3'd3;
    localparam logic [2:0] CFG_SEL_TX = 3'd4;
    localparam logic [2:0] CFG_SEL_TY = 3'd5;
    localparam int         NUM_CFG    = 6;

    // The forward mapper needs ten enabled cycles per pass
    localparam int         NUM_PHASES = 10;
    localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES - 1);

    // Matrix reset values: identity with 1.0 encoded as 0x010
    localparam logic [11:0] MATRIX_ONE  = 12'h010;
    localparam logic [11:0] MATRIX_ZERO = 12'h000;

endpackage

// File: rtl/ibis_mapper_result_buffer.sv
// One-deep valid/ready register slice holding a mapper result.
// A load is accepted unless the slot is full and the consumer is not ready;
// that condition is exported as o_stall so the scheduler can freeze the mapper.
module ibis_mapper_result_buffer #(
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_stall
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    assign o_stall = r_valid && !i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slot register: load wins over drain so capture and consume can overlap
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load && !o_stall) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ibis_mapper_scheduler.sv
// Walks a rectangular pixel span through the 10-phase forward mapper:
// one pixel issued per pass, each pass's result collected at the next
// phase 0 and presented on a valid/ready stream. Matrix/translate writes
// are held in shadow registers and committed to the mapper on a pass boundary.
module ibis_mapper_scheduler
    import ibis_mapper_pkg::*;
#(
    parameter int TILE_SIZE_POW2 = 5,
    parameter int WIDTH          = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            span_x0,
    input  logic [WIDTH-1:0]            span_y0,
    input  logic [WIDTH-1:0]            span_w,
    input  logic [WIDTH-1:0]            span_h,
    output logic                        busy,
    output logic                        done,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [2:0]                  cfg_sel,
    input  logic [11:0]                 cfg_data,
    output logic                        mapper_enable,
    output logic [5:0]                  mapper_write_matrix,
    output logic [WIDTH-1:0]            mapper_x,
    output logic [WIDTH-1:0]            mapper_y,
    output logic [11:0]                 mapper_A,
    output logic [11:0]                 mapper_B,
    output logic [11:0]                 mapper_C,
    output logic [11:0]                 mapper_D,
    output logic [WIDTH-1:0]            mapper_tx,
    output logic [WIDTH-1:0]            mapper_ty,
    input  logic [2*TILE_SIZE_POW2-1:0] mapper_map_address,
    input  logic                        mapper_stencil,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_x,
    output logic [WIDTH-1:0]            out_y,
    output logic [2*TILE_SIZE_POW2-1:0] out_address,
    output logic                        out_stencil
);

    localparam int AW = 2 * TILE_SIZE_POW2;
    // Buffer payload: {last, x, y, address, stencil}
    localparam int DW = 1 + 2 * WIDTH + AW + 1;

    // Control state
    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_phase;
    logic [NUM_CFG-1:0]   r_pending;
    logic [NUM_CFG-1:0]   w_pending_next;
    logic                 r_done;

    // Shadow matrix / translate registers
    logic [11:0]          r_a, r_b, r_c, r_d;
    logic [WIDTH-1:0]     r_tx, r_ty;

    // Span walk: latched geometry, issue counters and in-flight pixel
    logic [WIDTH-1:0]     r_x0, r_w, r_h;
    logic [WIDTH-1:0]     r_cnt_x, r_cnt_y;
    logic [WIDTH-1:0]     r_col, r_row;
    logic [WIDTH-1:0]     r_fl_x, r_fl_y;
    logic                 r_inflight;

    // Combinational strobes
    logic                 w_enable;
    logic                 w_phase0;
    logic                 w_capture_req;
    logic                 w_stall;
    logic                 w_load;
    logic                 w_issue;
    logic                 w_commit;
    logic                 w_row_end;
    logic                 w_last_pixel;
    logic                 w_span_empty;
    logic                 w_span_accept;
    logic                 w_cfg_we;
    logic [DW-1:0]        w_buf_in;
    logic [DW-1:0]        w_buf_out;
    logic                 w_buf_last;

    assign w_phase0      = (r_phase == 4'd0);
    // r_inflight is only ever set outside IDLE, so this is a RUN/DRAIN capture point
    assign w_capture_req = w_phase0 && r_inflight;
    assign w_load        = w_capture_req && !w_stall;
    assign w_issue       = (r_state == RUN) && w_phase0 && w_enable;
    assign w_commit      = w_enable && w_phase0;
    assign w_row_end     = (r_col == r_w - 1'b1);
    assign w_last_pixel  = w_row_end && (r_row == r_h - 1'b1);
    assign w_span_empty  = (span_w == '0) || (span_h == '0);
    assign w_span_accept = (r_state == IDLE) && start && !w_span_empty;
    assign w_cfg_we      = cfg_valid && (cfg_sel <= CFG_SEL_TY);

    // Next state and mapper enable; RUN only drops enable while stalled,
    // DRAIN parks the mapper at phase 0 on its capture cycle, IDLE runs a
    // pass only to deliver pending config (and then to finish that pass).
    always_comb begin
        w_state_next = r_state;
        w_enable     = 1'b0;
        case (r_state)
            IDLE: begin
                w_enable = (r_phase != 4'd0) || (r_pending != '0);
                if (start && !w_span_empty) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_enable = !(w_capture_req && w_stall);
                if (w_enable && w_phase0 && w_last_pixel) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_enable = !w_phase0;
                if (w_load) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase tracks the mapper's internal state: moves only when enabled
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_phase <= 4'd0;
        end else if (w_enable) begin
            r_phase <= (r_phase == LAST_PHASE) ? 4'd0 : r_phase + 4'd1;
        end
    end

    // Per-field pending bits: a write landing on a commit cycle survives it
    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_pending
        assign w_pending_next[gi] = (w_cfg_we && (cfg_sel == 3'(gi))) ||
                                    (r_pending[gi] && !w_commit);
    end

    // Pending mask register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Shadow registers; the mapper sees the old value during a same-cycle commit
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_a  <= MATRIX_ONE;
            r_b  <= MATRIX_ZERO;
            r_c  <= MATRIX_ZERO;
            r_d  <= MATRIX_ONE;
            r_tx <= '0;
            r_ty <= '0;
        end else if (w_cfg_we) begin
            case (cfg_sel)
                CFG_SEL_A:  r_a  <= cfg_data;
                CFG_SEL_B:  r_b  <= cfg_data;
                CFG_SEL_C:  r_c  <= cfg_data;
                CFG_SEL_D:  r_d  <= cfg_data;
                CFG_SEL_TX: r_tx <= cfg_data[WIDTH-1:0];
                CFG_SEL_TY: r_ty <= cfg_data[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Span walker: latch geometry on start, step raster order on each issue
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_x0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_cnt_x <= '0;
            r_cnt_y <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_fl_x  <= '0;
            r_fl_y  <= '0;
        end else if (w_span_accept) begin
            r_x0    <= span_x0;
            r_w     <= span_w;
            r_h     <= span_h;
            r_cnt_x <= span_x0;
            r_cnt_y <= span_y0;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_issue) begin
            r_fl_x <= r_cnt_x;
            r_fl_y <= r_cnt_y;
            if (w_row_end) begin
                r_col   <= '0;
                r_row   <= r_row + 1'b1;
                r_cnt_x <= r_x0;
                r_cnt_y <= r_cnt_y + 1'b1;
            end else begin
                r_col   <= r_col + 1'b1;
                r_cnt_x <= r_cnt_x + 1'b1;
            end
        end
    end

    // In-flight flag: set by an issue, cleared once DRAIN collects the last result
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight <= 1'b1;
        end else if ((r_state == DRAIN) && w_load) begin
            r_inflight <= 1'b0;
        end
    end

    // Done pulse: empty span accepted, or the span's last result consumed
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ((r_state == IDLE) && start && w_span_empty) ||
                      (out_valid && out_ready && w_buf_last);
        end
    end

    assign w_buf_in = {(r_state == DRAIN), r_fl_x, r_fl_y,
                       mapper_map_address, mapper_stencil};

    ibis_mapper_result_buffer #(
        .DW (DW)
    ) u_result_buffer (
        .aclk    (aclk),
        .areset  (areset),
        .i_load  (w_load),
        .i_data  (w_buf_in),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (w_buf_out),
        .o_stall (w_stall)
    );

    assign {w_buf_last, out_x, out_y, out_address, out_stencil} = w_buf_out;

    assign busy                = (r_state != IDLE);
    assign done                = r_done;
    assign cfg_ready           = 1'b1;
    assign mapper_enable       = w_enable;
    assign mapper_write_matrix = w_commit ? r_pending : '0;
    // RUN presents the next pixel; DRAIN repeats the last pixel as a dummy
    assign mapper_x            = (r_state == RUN) ? r_cnt_x : r_fl_x;
    assign mapper_y            = (r_state == RUN) ? r_cnt_y : r_fl_y;
    assign mapper_A            = r_a;
    assign mapper_B            = r_b;
    assign mapper_C            = r_c;
    assign mapper_D            = r_d;
    assign mapper_tx           = r_tx;
    assign mapper_ty           = r_ty;

endmodule

// File: doc/ibis_mapper_scheduler.md
Name: ibis_mapper_scheduler

Overview:
Sequences the 10-phase texture forward mapper across a rectangular pixel span: issues one (x, y) per mapper pass, collects each pass's map address and stencil result, and presents it on a valid/ready stream.
Owns the mapper's enable and write_matrix strobes. Matrix/translate updates are staged in shadow registers and committed only at a pass boundary.
Sits between the tile rasteriser control and the forward mapper / texture fetch.

Parameters:
TILE_SIZE_POW2, 5, log2 tile edge; address width is 2*TILE_SIZE_POW2
WIDTH, 10, coordinate and span-count width

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
start  in  1  pulse; begins span when IDLE, ignored otherwise
span_x0  in  WIDTH  first x
span_y0  in  WIDTH  first y
span_w  in  WIDTH  pixels per row
span_h  in  WIDTH  rows
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when the last result is accepted, or on an empty span
cfg_valid  in  1  config write request
cfg_ready  out  1  constant 1 (always accepts)
cfg_sel  in  3  0..3 = A..D, 4 = Tx, 5 = Ty; 6..7 ignored
cfg_data  in  12  matrix value (signed); Tx/Ty use [WIDTH-1:0]
mapper_enable  out  1  to mapper enable
mapper_write_matrix  out  6  to mapper write_matrix
mapper_x, mapper_y  out  WIDTH  to mapper x, y
mapper_A..D  out  12 each  shadow matrix registers
mapper_tx, mapper_ty  out  WIDTH  shadow translate registers
mapper_map_address  in  2*TILE_SIZE_POW2  from mapper
mapper_stencil  in  1  from mapper stencil_test
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_x, out_y  out  WIDTH  coordinate of the result
out_address  out  2*TILE_SIZE_POW2  map address
out_stencil  out  1  stencil pass

Behaviour:
- Reset values: state IDLE, phase 0, pending mask 0, out_valid 0, done 0, busy 0, mapper_enable 0. Shadows reset to A = D = 12'sh010; B, C, tx, ty = 0.
- The mapper is reset from the same source, so phase 0 mirrors mapper state[0]. Phase 0..9 advances, with wrap, only on cycles with mapper_enable = 1.
- States:
  - IDLE: on start, if span_w == 0 or span_h == 0, pulse done next cycle and stay IDLE. Otherwise latch the span, set counters to (x0, y0) and go to RUN.
  - RUN: mapper_enable = 1 except during a stall.
  - DRAIN: one extra pass issues a dummy pixel (x/y = last pixel) so the final result can be collected. At its phase 0, capture the result, then go to IDLE and pulse done when out_valid is consumed.
- Pixel issue:
  - mapper_x/y are driven from the counters during phase 0. x increments after each phase-0 issue; when the row count is reached, x returns to x0 and y increments.
  - After the last pixel is issued, go to DRAIN. Coordinates wrap modulo 2^WIDTH.
- Result capture:
  - At phase 0 with a pixel in flight, the mapper outputs hold the previous pass's result. Load out_* with that result and the in-flight coordinate.
  - Stall: if out_valid = 1 and out_ready = 0 at a capture point, hold mapper_enable = 0 and stay in phase 0 until the buffer frees.
  - When out_valid and out_ready are both high, capture and advance in the same cycle. Latency from issue to out_valid is 10 enabled cycles plus 1.
- Config:
  - cfg_valid with sel 0..5 writes the shadow register and sets pending[sel].
  - At the next enabled phase-0 cycle (any state, including IDLE pulsing enable once if pending != 0), mapper_write_matrix = pending and pending clears.
  - Write on the same cycle as a commit: the new bit stays pending for the next pass. The mapper sees the old shadow value during that commit.
- Reset mid-operation: immediate return to reset values. In-flight results are discarded; pending config is discarded.

Decomposition:
- Package ibis_mapper_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - cfg_sel constants A..TY
  - the 10-phase count constant
  - matrix reset constants
- One sub-module, ibis_mapper_result_buffer: a one-deep valid/ready register slice with a stall output.

Test Plan:
- Span x0 = 3, y0 = 5, w = 2, h = 2, identity matrix, out_ready = 1 -> four results at (3,5), (4,5), (3,6), (4,6), one every 10 cycles; done pulses after the 4th.
- span_w = 0 with start -> done next cycle, mapper_enable never asserted, busy stays 0.
- out_ready held 0 for 25 cycles after the first result -> mapper_enable low, phase frozen at 0, no result lost or duplicated.
- cfg_sel = 4, data = 8 during RUN at phase 3 -> mapper_write_matrix = 6'b010000 for exactly one cycle at the next phase 0.
- cfg write on a commit cycle -> the bit is re-committed on the following pass with the new value.
- areset asserted mid-RUN at phase 6 -> all outputs at reset values asynchronously; next start behaves as the first test.
